mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline. It starts mult/multu/div/divu, holds the multi-cycle latency, owns the HI/LO registers, and services mfhi/mflo/mthi/mtlo. It raises a stall request to hazard control whenever a D-stage HI/LO-class instruction must wait. Command codes are the 6-bit codes produced by the instruction decoder.

Parameters:
MULT_CYCLES, 5, cycles busy after a mult/multu start (>=1)
DIV_CYCLES, 10, cycles busy after a div/divu start (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_e  in  6  decoded command of E-stage instruction
cmd_d  in  6  decoded command of D-stage instruction
rs_e  in  32  forwarded rs value, E stage
rt_e  in  32  forwarded rt value, E stage
cancel  in  1  exception/interrupt flush of E stage this cycle
hi  out  32  HI register
lo  out  32  LO register
start  out  1  combinational: E-stage mult/div accepted this cycle
busy  out  1  registered: operation in flight
stall_req  out  1  combinational: stall D stage

Behaviour:
- Codes: mult 0x12, multu 0x13, div 0x14, divu 0x15, mfhi 0x16, mflo 0x17, mthi 0x18, mtlo 0x19. "md-class" means any of 0x12..0x19.
- Reset: hi=0, lo=0, busy=0, counter=0, pending result discarded. Reset mid-operation aborts with no HI/LO commit.
- States: IDLE (counter==0) and BUSY (counter!=0). busy = (counter!=0).
- start = (cmd_e in 0x12..0x15) & !busy & !cancel.
- On an edge with start: latch the 64-bit result into a pending register. Load counter with MULT_CYCLES or DIV_CYCLES.
- In BUSY: counter decrements each edge. On the edge where counter==1, {hi,lo} <= pending and counter <= 0. busy is therefore high for exactly N cycles after the start cycle. New hi/lo are visible on the cycle busy falls.
- mult: signed 32x32 -> 64 product, hi = [63:32], lo = [31:0]. multu: unsigned.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. divu: unsigned.
- Divide by zero: the operation still runs for the full DIV_CYCLES latency, then hi/lo are left unchanged.
- mthi/mtlo: when !cancel, hi (or lo) <= rs_e at the edge, no latency. If one coincides with an in-flight result, the later pending commit overwrites it; the stall rule prevents this in normal flow.
- mfhi/mflo: the datapath reads the hi/lo ports directly. No action in this block.
- stall_req = md-class(cmd_d) & (start | busy).
- cancel blocks start and mthi/mtlo in that cycle. It never aborts an operation already in BUSY.
- If start occurs while busy: impossible under the stall rule; the command is ignored.

Optional Feature:
MDU_MADD_EN
- Defined: adds codes madd 0x21 and maddu 0x22 as members of the start set and the md-class set.
- The pending result is {hi,lo} + product (signed/unsigned), mod 2^64, using hi/lo sampled at the start edge.
- Latency is MULT_CYCLES.
- Undefined: 0x21/0x22 are not md-class and have no effect.

Decomposition:
- Shared package: command code constants (same definitions the decoder uses), MULT_CYCLES/DIV_CYCLES defaults, and a counter width constant of 4 bits (sized for the DIV_CYCLES default; must hold max(MULT_CYCLES, DIV_CYCLES)).
- One sub-module, mdu_arith: purely combinational 64-bit result from op, rs, rt (plus hi/lo when MDU_MADD_EN is defined).
- mdu_ctrl holds the counter, the pending register and HI/LO.

Test Plan:
- mult rs=0xFFFFFFFF, rt=2 -> start=1 for 1 cycle, busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> busy=1 for 10 cycles, hi/lo unchanged.
- mult issued with cmd_d=mflo held -> stall_req=1 on the start cycle plus the 5 busy cycles (6 total), 0 on the 7th. With cmd_d=add -> stall_req stays 0.
- mthi rs=0x12345678 -> hi=0x12345678 next cycle. The same with cancel=1 -> hi unchanged. mult with cancel=1 -> start=0, busy stays 0.
- div started, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0; no commit occurs afterwards.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd rs=1, rt=1 -> after 5 cycles hi=0x00000001, lo=0x00000000.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: decoder command codes,
// default latencies, counter width and command-class helpers.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu).
package mdu_ctrl_pkg;

  // Command codes, identical to the instruction decoder's encoding
  localparam logic [5:0] CMD_MULT  = 6'h12;
  localparam logic [5:0] CMD_MULTU = 6'h13;
  localparam logic [5:0] CMD_DIV   = 6'h14;
  localparam logic [5:0] CMD_DIVU  = 6'h15;
  localparam logic [5:0] CMD_MFHI  = 6'h16;
  localparam logic [5:0] CMD_MFLO  = 6'h17;
  localparam logic [5:0] CMD_MTHI  = 6'h18;
  localparam logic [5:0] CMD_MTLO  = 6'h19;
  localparam logic [5:0] CMD_MADD  = 6'h21;
  localparam logic [5:0] CMD_MADDU = 6'h22;

  // Default latencies and the counter width that must hold the larger one
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // Commands that launch a multi-cycle operation
  function automatic logic is_start_cmd(input logic [5:0] c);
    logic r;
    r = (c == CMD_MULT) || (c == CMD_MULTU) || (c == CMD_DIV) || (c == CMD_DIVU);
`ifdef MDU_MADD_EN
    r = r || (c == CMD_MADD) || (c == CMD_MADDU);
`endif
    return r;
  endfunction

  // Any instruction that touches HI/LO
  function automatic logic is_md_cmd(input logic [5:0] c);
    logic r;
    r = (c >= CMD_MULT) && (c <= CMD_MTLO);
`ifdef MDU_MADD_EN
    r = r || (c == CMD_MADD) || (c == CMD_MADDU);
`endif
    return r;
  endfunction

  function automatic logic is_div_cmd(input logic [5:0] c);
    return (c == CMD_DIV) || (c == CMD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Purely combinational 64-bit result generator for mult/multu/div/divu
// (and madd/maddu when MDU_MADD_EN is defined). res_ok is low for a divide
// by zero, meaning HI/LO must be left untouched.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [63:0] res,
  output logic        res_ok
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Products: sign-extended operands give the signed product modulo 2^64
  always_comb begin
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'd0, rs} * {32'd0, rt};
  end

  // Division on magnitudes, then sign fix-up: quotient truncates toward zero,
  // remainder follows the dividend. A zero divisor is replaced by 1 so the
  // divider never sees it; the result is discarded anyway.
  always_comb begin
    div_signed = (op == CMD_DIV);
    neg_q      = div_signed && (rs[31] ^ rt[31]);
    neg_r      = div_signed && rs[31];
    dvd_mag    = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
    dvs_mag    = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
    dvs_safe   = (rt == 32'd0) ? 32'd1 : dvs_mag;
    q_mag      = dvd_mag / dvs_safe;
    r_mag      = dvd_mag % dvs_safe;
    quo        = neg_q ? (32'd0 - q_mag) : q_mag;
    rem        = neg_r ? (32'd0 - r_mag) : r_mag;
  end

  // Select the result for the requested operation
  always_comb begin
    res    = 64'd0;
    res_ok = 1'b1;
    case (op)
      CMD_MULT:  res = prod_s;
      CMD_MULTU: res = prod_u;
      CMD_DIV, CMD_DIVU: begin
        res    = {rem, quo};
        res_ok = (rt != 32'd0);
      end
`ifdef MDU_MADD_EN
      CMD_MADD:  res = {hi, lo} + prod_s;
      CMD_MADDU: res = {hi, lo} + prod_u;
`endif
      default: begin
        res    = 64'd0;
        res_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: launches operations, holds the
// multi-cycle latency, owns HI/LO, services mthi/mtlo and requests D-stage
// stalls for HI/LO-class instructions. Optional feature macro: MDU_MADD_EN.
// Handshake: start is a single-cycle pulse with no ready; a command is taken
// only when it is a start command, busy is low and cancel is low. Anything
// else presented meanwhile is dropped, and stall_req keeps D-stage md-class
// instructions from reaching E until busy falls.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  cmd_e,
  input  logic [5:0]  cmd_d,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        start,
  output logic        busy,
  output logic        stall_req
);

  localparam logic [CNT_W-1:0] MULT_LD = MULT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_LD  = DIV_CYCLES[CNT_W-1:0];

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_ok_q, pend_ok_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      arith_res;
  logic             arith_ok;

  mdu_arith u_arith (
    .op     (cmd_e),
    .rs     (rs_e),
    .rt     (rt_e),
`ifdef MDU_MADD_EN
    .hi     (hi_q),
    .lo     (lo_q),
`endif
    .res    (arith_res),
    .res_ok (arith_ok)
  );

  // Outputs: busy is the registered state, start/stall_req are combinational
  always_comb begin
    busy      = (state_q == S_BUSY);
    start     = is_start_cmd(cmd_e) && !busy && !cancel;
    stall_req = is_md_cmd(cmd_d) && (start || busy);
    hi        = hi_q;
    lo        = lo_q;
  end

  // Next state: launch, count down, commit; mthi/mtlo first so a commit wins
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (!cancel && (cmd_e == CMD_MTHI)) hi_d = rs_e;
    if (!cancel && (cmd_e == CMD_MTLO)) lo_d = rs_e;

    if (start) begin
      pend_d    = arith_res;
      pend_ok_d = arith_ok;
      cnt_d     = is_div_cmd(cmd_e) ? DIV_LD : MULT_LD;
      state_d   = S_BUSY;
    end else if (state_q == S_BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (pend_ok_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with immediate-assertion checks.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam logic [5:0] CMD_NOP = 6'h00;
  localparam logic [5:0] CMD_ADD = 6'h01;

  logic        clk;
  logic        reset;
  logic [5:0]  cmd_e;
  logic [5:0]  cmd_d;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start;
  logic        busy;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_e     (cmd_e),
    .cmd_d     (cmd_d),
    .rs_e      (rs_e),
    .rt_e      (rt_e),
    .cancel    (cancel),
    .hi        (hi),
    .lo        (lo),
    .start     (start),
    .busy      (busy),
    .stall_req (stall_req)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start command and follow it through its latency
  task automatic run_op(input logic [5:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [5:0] dcmd, input logic exp_stall);
    cmd_e = cmd; rs_e = a; rt_e = b; cmd_d = dcmd;
    #1;
    check("start_pulse", start, 1);
    check("busy_at_start", busy, 0);
    check("stall_at_start", stall_req, exp_stall);
    tick();
    cmd_e = CMD_NOP;
    #1;
    check("start_low_after", start, 0);
    for (int i = 0; i < n; i++) begin
      check("busy_hold", busy, 1);
      check("stall_hold", stall_req, exp_stall);
      tick();
    end
    check("busy_fall", busy, 0);
    check("stall_after", stall_req, 0);
  endtask

  initial begin
    // Reset
    reset = 1'b1; cmd_e = CMD_NOP; cmd_d = CMD_NOP; rs_e = '0; rt_e = '0; cancel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_stall", stall_req, 0);

    // mult -1 * 2
    run_op(CMD_MULT, 32'hFFFFFFFF, 32'd2, 5, CMD_NOP, 1'b0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    // multu 0xFFFFFFFF * 2
    run_op(CMD_MULTU, 32'hFFFFFFFF, 32'd2, 5, CMD_NOP, 1'b0);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2
    run_op(CMD_DIV, 32'hFFFFFFF9, 32'd2, 10, CMD_NOP, 1'b0);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    // divu 7 / 0 leaves HI/LO unchanged
    run_op(CMD_DIVU, 32'd7, 32'd0, 10, CMD_NOP, 1'b0);
    check("div0_lo", lo, 32'hFFFFFFFD);
    check("div0_hi", hi, 32'hFFFFFFFF);

    // Overflow corner of signed divide
    run_op(CMD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, CMD_NOP, 1'b0);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h00000000);

    // divu 100 / 7
    run_op(CMD_DIVU, 32'd100, 32'd7, 10, CMD_NOP, 1'b0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Stall with mflo in D for start + 5 busy cycles, then released
    run_op(CMD_MULT, 32'd3, 32'd4, 5, CMD_MFLO, 1'b1);
    check("stall_mult_lo", lo, 32'd12);
    // No stall for a non-md D-stage instruction
    run_op(CMD_MULT, 32'd5, 32'd6, 5, CMD_ADD, 1'b0);
    check("nostall_mult_lo", lo, 32'd30);
    cmd_d = CMD_NOP;

    // mthi / mtlo
    cmd_e = CMD_MTHI; rs_e = 32'h12345678;
    tick();
    cmd_e = CMD_NOP; #1;
    check("mthi", hi, 32'h12345678);
    cmd_e = CMD_MTLO; rs_e = 32'hCAFEF00D;
    tick();
    cmd_e = CMD_NOP; #1;
    check("mtlo", lo, 32'hCAFEF00D);
    cmd_e = CMD_MTHI; rs_e = 32'hDEADBEEF; cancel = 1'b1;
    tick();
    cmd_e = CMD_NOP; cancel = 1'b0; #1;
    check("mthi_cancel", hi, 32'h12345678);

    // Cancelled mult never starts
    cmd_e = CMD_MULT; rs_e = 32'd9; rt_e = 32'd9; cancel = 1'b1;
    #1;
    check("cancel_start", start, 0);
    tick();
    cmd_e = CMD_NOP; cancel = 1'b0; #1;
    check("cancel_busy", busy, 0);
    check("cancel_lo", lo, 32'hCAFEF00D);

    // Reset during a divide aborts it with no later commit
    cmd_e = CMD_DIVU; rs_e = 32'd100; rt_e = 32'd7;
    tick();
    cmd_e = CMD_NOP;
    tick(); tick(); tick();
    #1;
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_nocommit_hi", hi, 0);
    check("abort_nocommit_lo", lo, 0);
    check("abort_idle", busy, 0);

`ifdef MDU_MADD_EN
    // madd accumulates onto HI/LO
    cmd_e = CMD_MTLO; rs_e = 32'hFFFFFFFF;
    tick();
    cmd_e = CMD_MTHI; rs_e = 32'h0;
    tick();
    cmd_e = CMD_NOP;
    run_op(CMD_MADD, 32'd1, 32'd1, 5, CMD_NOP, 1'b0);
    check("madd_hi", hi, 32'h00000001);
    check("madd_lo", lo, 32'h00000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
